// File: rtl/hub75_bcm_scanner_if.sv
// Framebuffer read port and HUB75 panel pins of the scan driver.
// master = scanner side, slave = framebuffer/panel side.
interface hub75_bcm_scanner_if #(
    parameter int COLS      = 32,
    parameter int ADDR_BITS = 3,
    parameter int BPC       = 4
);
    localparam int AW = ADDR_BITS + $clog2(COLS);

    logic [AW-1:0]        rd_addr;
    logic [6*BPC-1:0]     rd_data;
    logic                 r1;
    logic                 g1;
    logic                 b1;
    logic                 r2;
    logic                 g2;
    logic                 b2;
    logic [ADDR_BITS-1:0] abc;
    logic                 oclk;
    logic                 lat;
    logic                 oe;
    logic                 frame_start;

    modport master (
        output rd_addr,
        input  rd_data,
        output r1, g1, b1, r2, g2, b2,
        output abc, oclk, lat, oe, frame_start
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  r1, g1, b1, r2, g2, b2,
        input  abc, oclk, lat, oe, frame_start
    );
endinterface

// File: rtl/hub75_bcm_scanner.sv
// HUB75 row-pair scan driver with binary-coded modulation over BPC bit-planes.
// Define HUB75_TESTPAT_EN to replace framebuffer colour with a row-index test pattern.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_FETCH | frame_start for row 0 / plane 0; column 0 read in flight
// S_SHIFT | two phases per column: load colour + oclk low, oclk high
// S_BLANK | panel blanked, shift clock parked low
// S_LATCH | latch pulse, row address updated while blanked
// S_SHOW  | display for BASE_ON<<plane cycles, then next plane/row
module hub75_bcm_scanner #(
    parameter int COLS      = 32,
    parameter int ADDR_BITS = 3,
    parameter int BPC       = 4,
    parameter int BASE_ON   = 32
) (
    input logic                 clk,
    input logic                 reset,
    hub75_bcm_scanner_if.master bus
);
    localparam int CW    = $clog2(COLS);
    localparam int PW    = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int MAXON = BASE_ON << (BPC - 1);
    localparam int DW    = $clog2(MAXON + 1);
    localparam int AW    = ADDR_BITS + CW;

    typedef enum logic [2:0] {
        S_FETCH,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_SHOW
    } state_t;

    state_t               state, state_n;
    logic [ADDR_BITS-1:0] row, row_n;
    logic [PW-1:0]        plane, plane_n;
    logic [CW-1:0]        col, col_n;
    logic                 phase, phase_n;
    logic [DW-1:0]        disp, disp_n;

    logic [AW-1:0]        rd_addr_q, rd_addr_n;
    logic [5:0]           rgb_q, rgb_n;
    logic [ADDR_BITS-1:0] abc_q, abc_n;
    logic                 oclk_q, oclk_n;
    logic                 lat_q, lat_n;
    logic                 oe_q, oe_n;
    logic                 fs_q, fs_n;

    // pix = {top_r, top_g, top_b, bot_r, bot_g, bot_b} for the current plane
    logic [5:0]           pix;

`ifdef HUB75_TESTPAT_EN
    logic [2:0] row_pat;
    assign row_pat = 3'(row);
    assign pix     = {row_pat, row_pat};
`else
    always_comb begin
        pix = '0;
        for (int f = 0; f < 6; f++) begin
            pix[f] = bus.rd_data[f*BPC + int'(plane)];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            row       <= '0;
            plane     <= '0;
            col       <= '0;
            phase     <= 1'b0;
            disp      <= '0;
            rd_addr_q <= '0;
            rgb_q     <= '0;
            abc_q     <= '0;
            oclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            oe_q      <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            plane     <= plane_n;
            col       <= col_n;
            phase     <= phase_n;
            disp      <= disp_n;
            rd_addr_q <= rd_addr_n;
            rgb_q     <= rgb_n;
            abc_q     <= abc_n;
            oclk_q    <= oclk_n;
            lat_q     <= lat_n;
            oe_q      <= oe_n;
            fs_q      <= fs_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_n     = row;
        plane_n   = plane;
        col_n     = col;
        phase_n   = phase;
        disp_n    = disp;
        rd_addr_n = rd_addr_q;
        rgb_n     = rgb_q;
        abc_n     = abc_q;
        oclk_n    = oclk_q;
        lat_n     = lat_q;
        oe_n      = oe_q;
        fs_n      = 1'b0;

        case (state)
            S_FETCH: begin
                fs_n    = (row == '0) && (plane == '0);
                oe_n    = 1'b1;
                col_n   = '0;
                phase_n = 1'b0;
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                if (!phase) begin
                    // data for column col arrives now; the next column's read is issued
                    rgb_n     = pix;
                    oclk_n    = 1'b0;
                    rd_addr_n = {row, col + CW'(1)};
                    phase_n   = 1'b1;
                end else begin
                    oclk_n  = 1'b1;
                    phase_n = 1'b0;
                    col_n   = col + CW'(1);
                    if (col == CW'(COLS - 1)) begin
                        state_n = S_BLANK;
                    end
                end
            end
            S_BLANK: begin
                oe_n    = 1'b1;
                oclk_n  = 1'b0;
                state_n = S_LATCH;
            end
            S_LATCH: begin
                lat_n   = 1'b1;
                abc_n   = row;
                disp_n  = DW'(BASE_ON << plane) - DW'(1);
                state_n = S_SHOW;
            end
            S_SHOW: begin
                oe_n  = 1'b0;
                lat_n = 1'b0;
                if (disp == '0) begin
                    state_n = S_FETCH;
                    if (plane == PW'(BPC - 1)) begin
                        plane_n   = '0;
                        row_n     = row + ADDR_BITS'(1);
                        // column 0 of the next row must be on the bus during FETCH
                        rd_addr_n = {row + ADDR_BITS'(1), CW'(0)};
                    end else begin
                        plane_n = plane + PW'(1);
                    end
                end else begin
                    disp_n = disp - DW'(1);
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    assign bus.rd_addr     = rd_addr_q;
    assign bus.r1          = rgb_q[5];
    assign bus.g1          = rgb_q[4];
    assign bus.b1          = rgb_q[3];
    assign bus.r2          = rgb_q[2];
    assign bus.g2          = rgb_q[1];
    assign bus.b2          = rgb_q[0];
    assign bus.abc         = abc_q;
    assign bus.oclk        = oclk_q;
    assign bus.lat         = lat_q;
    assign bus.oe          = oe_q;
    assign bus.frame_start = fs_q;
endmodule
